viterbi_decode_ctrl: RTL and testbench
======================================

Name: viterbi_decode_ctrl

Overview:
Sequencer for one Viterbi decode pass over a 16-bit packet held in the input buffer (8 two-bit symbol pairs). It clears path metrics, steps the branch-metric/ACS datapath through the 8 trellis stages by driving the pair select, runs the traceback, and presents the decoded result to the downstream consumer. After the consumer accepts the result, it pulses refresh so the input buffer advances its FIFO.

Parameters:
NUM_STAGES, 8, trellis stages per packet; equals the bit pairs per packet; pair_sel/tb_step index width is 3 bits.
ACS_LAT, 1, cycles each ACS stage occupies (1..4); acs_en pulses only on the first cycle of a stage.
CNT_W, 8, width of the completed-packet counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
pkt_valid  input  1  input buffer holds a packet ready to decode
flush  input  1  synchronous abort; return to IDLE without refresh
out_ready  input  1  consumer accepts decoded result
pair_sel  output  3  index of bit pair fed to branch-metric unit
pm_clear  output  1  one-cycle path-metric clear
acs_en  output  1  ACS update strobe for stage pair_sel
tb_en  output  1  traceback step strobe
tb_step  output  3  traceback stage index, counts down
out_valid  output  1  decoded result valid
refresh  output  1  one-cycle pulse to input buffer
busy  output  1  high in every state except IDLE
pkt_count  output  CNT_W  completed packets, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): state=IDLE; pair_sel=0, tb_step=0, stage/lat counters=0, pkt_count=0; all strobes, out_valid and busy =0.
- All outputs registered or decoded from state/counters only; no combinational input-to-output paths except none (out_valid does not depend on out_ready).
- States: IDLE, INIT, ACS, TB, OUT, REFRESH.
- IDLE: pkt_valid=1 -> INIT next cycle.
- INIT (1 cycle): pm_clear=1; stage=0, lat=0 -> ACS.
- ACS: pair_sel=stage; acs_en=1 when lat==0. lat increments; at lat==ACS_LAT-1, lat<=0 and stage++. On stage==NUM_STAGES-1 and lat==ACS_LAT-1 -> TB, tb_step<=NUM_STAGES-1. ACS occupies exactly NUM_STAGES*ACS_LAT cycles.
- TB: tb_en=1 every cycle, tb_step = current step; decrement; after step 0 -> OUT. Exactly NUM_STAGES cycles.
- OUT: out_valid=1, held stable until a cycle with out_ready=1; that cycle is the handshake -> REFRESH. out_ready while not in OUT is ignored.
- REFRESH (1 cycle): refresh=1; pkt_count increments (wraps 2^CNT_W-1 -> 0) -> IDLE.
- pkt_valid is ignored outside IDLE. The earliest next start is IDLE sampling pkt_valid one cycle after REFRESH, so the buffer always has its post-refresh data settled.
- Latency, ACS_LAT=1, pkt_valid high in IDLE cycle 0: INIT c1, ACS c2-c9 (pair_sel 0..7), TB c10-c17 (tb_step 7..0), OUT from c18, REFRESH on cycle after handshake.
- flush=1 in any non-IDLE state: next state IDLE, counters cleared, no refresh, pkt_count unchanged. flush has priority over every transition, including the OUT handshake. In IDLE, flush has priority over pkt_valid (no start).
- Strobes (pm_clear, acs_en, tb_en, refresh) are never asserted outside their state.

Test Plan:
- Reset mid-ACS (rst at stage 4) -> all outputs 0 immediately, state IDLE, pkt_count 0; a later pkt_valid starts a clean pass with pm_clear.
- Single packet, ACS_LAT=1, out_ready tied 1: pkt_valid at c0 -> pm_clear c1; acs_en c2-c9 with pair_sel 0..7; tb_en c10-c17 with tb_step 7..0; out_valid c18; refresh c19; pkt_count=1; busy low c20.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid held 6 cycles, refresh exactly once, after the handshake.
- ACS_LAT=3 -> acs_en pulses 8 times spaced 3 cycles apart; ACS spans 24 cycles; pair_sel is constant within each stage.
- Flush during TB (tb_step=3) -> IDLE next cycle, no refresh, pkt_count unchanged. Flush and out_ready together in OUT -> no refresh.
- 257 back-to-back packets with pkt_valid held high, CNT_W=8 -> pkt_count wraps to 1; exactly one idle cycle between refresh and the next pm_clear.

Source files
------------

// File: rtl/viterbi_decode_ctrl.sv
// Viterbi decode pass sequencer: path-metric clear, per-stage ACS stepping,
// traceback, result handshake and input-buffer refresh for one 16-bit packet.
module viterbi_decode_ctrl #(
  parameter int NUM_STAGES = 8,
  parameter int ACS_LAT    = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  input  logic             flush,
  input  logic             out_ready,
  output logic [2:0]       pair_sel,
  output logic             pm_clear,
  output logic             acs_en,
  output logic             tb_en,
  output logic [2:0]       tb_step,
  output logic             out_valid,
  output logic             refresh,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ACS, S_TB, S_OUT, S_REFRESH
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] stage;
  logic [1:0] lat;
  logic [2:0] tb_cnt;
  logic       last_lat, last_stage;

  assign last_lat   = (lat == 2'(ACS_LAT - 1));
  assign last_stage = (stage == 3'(NUM_STAGES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Result handshake: out_valid is raised in OUT and held, independent of
  // out_ready; a transfer happens in any cycle where both are high. flush
  // overrides every transition, including that transfer.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (pkt_valid) state_nxt = S_INIT;
        S_INIT:    state_nxt = S_ACS;
        S_ACS:     if (last_lat && last_stage) state_nxt = S_TB;
        S_TB:      if (tb_cnt == 3'd0) state_nxt = S_OUT;
        S_OUT:     if (out_ready) state_nxt = S_REFRESH;
        S_REFRESH: state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage     <= '0;
      lat       <= '0;
      tb_cnt    <= '0;
      pkt_count <= '0;
    end else if (flush) begin
      stage  <= '0;
      lat    <= '0;
      tb_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          stage <= '0;
          lat   <= '0;
        end
        S_ACS: begin
          if (last_lat) begin
            lat   <= '0;
            stage <= stage + 3'd1;
            if (last_stage) tb_cnt <= 3'(NUM_STAGES - 1);
          end else begin
            lat <= lat + 2'd1;
          end
        end
        S_TB:      if (tb_cnt != 3'd0) tb_cnt <= tb_cnt - 3'd1;
        S_REFRESH: pkt_count <= pkt_count + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode only from state and counters, so no input reaches them.
  always_comb begin
    pair_sel  = 3'd0;
    pm_clear  = 1'b0;
    acs_en    = 1'b0;
    tb_en     = 1'b0;
    tb_step   = 3'd0;
    out_valid = 1'b0;
    refresh   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_INIT: pm_clear = 1'b1;
      S_ACS: begin
        pair_sel = stage;
        acs_en   = (lat == 2'd0);
      end
      S_TB: begin
        tb_en   = 1'b1;
        tb_step = tb_cnt;
      end
      S_OUT:     out_valid = 1'b1;
      S_REFRESH: refresh = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_viterbi_decode_ctrl.sv
// Bench for viterbi_decode_ctrl: vector table, directed corner sequences and
// random traffic compared against a packet-position reference model.
module tb_viterbi_decode_ctrl;
  localparam int L     = 1;
  localparam int CNT_W = 8;
  localparam int P_OUT = 8 * L + 9;
  localparam int P_REF = P_OUT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pkt_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [2:0] pair_sel, tb_step;
  logic pm_clear, acs_en, tb_en, out_valid, refresh, busy;
  logic [CNT_W-1:0] pkt_count;

  logic pv3 = 1'b0, fl3 = 1'b0, or3 = 1'b1;
  logic [2:0] ps3, tbs3;
  logic pmc3, acs3, tbe3, ov3, rf3, bsy3;
  logic [CNT_W-1:0] cnt3;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  viterbi_decode_ctrl #(.NUM_STAGES(8), .ACS_LAT(L), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .flush(flush),
    .out_ready(out_ready), .pair_sel(pair_sel), .pm_clear(pm_clear),
    .acs_en(acs_en), .tb_en(tb_en), .tb_step(tb_step), .out_valid(out_valid),
    .refresh(refresh), .busy(busy), .pkt_count(pkt_count));

  viterbi_decode_ctrl #(.NUM_STAGES(8), .ACS_LAT(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst(rst), .pkt_valid(pv3), .flush(fl3),
    .out_ready(or3), .pair_sel(ps3), .pm_clear(pmc3),
    .acs_en(acs3), .tb_en(tbe3), .tb_step(tbs3), .out_valid(ov3),
    .refresh(rf3), .busy(bsy3), .pkt_count(cnt3));

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the pass (-1 idle, 0 init, then ACS
  // cycles, traceback cycles, the OUT wait and the refresh cycle).
  int m_pos = -1;
  int m_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos <= -1;
      m_cnt <= 0;
    end else if (m_pos < 0) begin
      if (pkt_valid && !flush) m_pos <= 0;
    end else if (flush) m_pos <= -1;
    else if (m_pos == P_OUT) begin
      if (out_ready) m_pos <= P_REF;
    end else if (m_pos == P_REF) begin
      m_pos <= -1;
      m_cnt <= (m_cnt + 1) % (1 << CNT_W);
    end else m_pos <= m_pos + 1;
  end

  always @(negedge clk) begin
    int p;
    bit in_acs, in_tb;
    if (chk_en) begin
      p = m_pos;
      in_acs = (p >= 1) && (p <= 8 * L);
      in_tb  = (p > 8 * L) && (p <= 8 * L + 8);
      chk("model busy", busy, int'(p >= 0));
      chk("model pm_clear", pm_clear, int'(p == 0));
      chk("model acs_en", acs_en, int'(in_acs && ((p - 1) % L == 0)));
      chk("model pair_sel", pair_sel, in_acs ? (p - 1) / L : 0);
      chk("model tb_en", tb_en, int'(in_tb));
      chk("model tb_step", tb_step, in_tb ? 7 - (p - 8 * L - 1) : 0);
      chk("model out_valid", out_valid, int'(p == P_OUT));
      chk("model refresh", refresh, int'(p == P_REF));
      chk("model pkt_count", pkt_count, m_cnt);
    end
  end

  typedef struct {
    logic pv, fl, ordy;
    int ps, pmc, acs, tbe, tbs, ov, rf, bsy, cnt;
  } vec_t;
  vec_t tbl[21];

  initial begin
    int found, n_ov, n_rf, ref_j, cnt_before, n_acs, first_tb, pmc_c;
    int acs_c[16];
    int n_ref, last_ref;

    // Single packet, out_ready tied high: cycle-by-cycle expectations.
    for (int i = 0; i < 21; i++) begin
      tbl[i] = '{pv: (i == 0), fl: 1'b0, ordy: 1'b1,
                 ps: (i >= 2 && i <= 9) ? i - 2 : 0,
                 pmc: int'(i == 1), acs: int'(i >= 2 && i <= 9),
                 tbe: int'(i >= 10 && i <= 17),
                 tbs: (i >= 10 && i <= 17) ? 17 - i : 0,
                 ov: int'(i == 18), rf: int'(i == 19),
                 bsy: int'(i >= 1 && i <= 19), cnt: (i == 20) ? 1 : 0};
    end

    chk_en = 1;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset pkt_count", pkt_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d pair_sel", i), pair_sel, tbl[i].ps);
      chk($sformatf("vec%0d pm_clear", i), pm_clear, tbl[i].pmc);
      chk($sformatf("vec%0d acs_en", i), acs_en, tbl[i].acs);
      chk($sformatf("vec%0d tb_en", i), tb_en, tbl[i].tbe);
      chk($sformatf("vec%0d tb_step", i), tb_step, tbl[i].tbs);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d refresh", i), refresh, tbl[i].rf);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d pkt_count", i), pkt_count, tbl[i].cnt);
      pkt_valid = tbl[i].pv;
      flush     = tbl[i].fl;
      out_ready = tbl[i].ordy;
    end

    // Backpressure: five stalled OUT cycles, handshake on the sixth.
    @(negedge clk);
    out_ready = 1'b0;
    pkt_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      if (out_valid) begin found = 1; break; end
    end
    chk("bp reached OUT", found, 1);
    n_ov = 1; n_rf = 0; ref_j = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (out_valid) n_ov++;
      if (refresh) begin n_rf++; ref_j = j; end
      out_ready = (j == 5);
    end
    chk("bp out_valid cycles", n_ov, 6);
    chk("bp refresh count", n_rf, 1);
    chk("bp refresh cycle", ref_j, 6);

    // Flush at traceback step 3.
    cnt_before = int'(pkt_count);
    pkt_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      if (tb_en && tb_step == 3'd3) begin found = 1; break; end
    end
    chk("flush tb reached", found, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush tb busy", busy, 0);
    n_rf = 0;
    for (int k = 0; k < 4; k++) begin
      if (refresh) n_rf++;
      @(negedge clk);
    end
    chk("flush tb refresh", n_rf, 0);
    chk("flush tb pkt_count", pkt_count, cnt_before);

    // Flush together with out_ready in OUT.
    pkt_valid = 1'b1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      pkt_valid = 1'b0;
      if (out_valid) begin found = 1; break; end
    end
    chk("flush out reached", found, 1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush out busy", busy, 0);
    chk("flush out refresh", refresh, 0);
    @(negedge clk);
    chk("flush out refresh later", refresh, 0);
    chk("flush out pkt_count", pkt_count, cnt_before);

    // ACS_LAT=3 instance: stage spacing and pair_sel stability.
    @(negedge clk);
    pv3 = 1'b1;
    n_acs = 0; first_tb = -1; pmc_c = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      pv3 = 1'b0;
      if (pmc3) pmc_c = c;
      if (acs3) begin
        if (n_acs < 16) acs_c[n_acs] = c;
        n_acs++;
      end
      if (tbe3 && first_tb < 0) first_tb = c;
      if (c >= 2 && c <= 25) chk($sformatf("lat3 pair_sel c%0d", c), ps3, (c - 2) / 3);
    end
    chk("lat3 pm_clear cycle", pmc_c, 1);
    chk("lat3 acs pulses", n_acs, 8);
    for (int k = 0; k < 8 && k < n_acs; k++) chk($sformatf("lat3 acs%0d cycle", k), acs_c[k], 2 + 3 * k);
    chk("lat3 first tb", first_tb, 26);
    chk("lat3 pkt_count", cnt3, 1);

    // Asynchronous reset while dut3 sits in ACS stage 4.
    pv3 = 1'b1;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      pv3 = 1'b0;
      if (acs3 && ps3 == 3'd4) begin found = 1; break; end
    end
    chk("rst reached stage4", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst busy", bsy3, 0);
    chk("rst acs_en", acs3, 0);
    chk("rst pair_sel", ps3, 0);
    chk("rst pkt_count", cnt3, 0);
    chk("rst main pkt_count", pkt_count, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    pv3 = 1'b1;
    @(negedge clk);
    pv3 = 1'b0;
    chk("rst restart pm_clear", pmc3, 1);

    // 257 back-to-back packets, pkt_valid held high.
    pkt_valid = 1'b1;
    out_ready = 1'b1;
    n_ref = 0; last_ref = -100;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (pm_clear && n_ref > 0) chk("b2b gap", c - last_ref, 2);
      if (refresh) begin
        n_ref++;
        last_ref = c;
        if (n_ref == 257) begin pkt_valid = 1'b0; break; end
      end
    end
    chk("b2b refresh count", n_ref, 257);
    @(negedge clk);
    @(negedge clk);
    chk("b2b pkt_count wrap", pkt_count, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pkt_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
